display_share_arbiter: RTL and testbench

- Shares the single 4-digit seven-segment display driver between three requesters: a result readout, a status/debug readout and a user-entry readout.
- Grants the display round-robin, with a minimum hold time so each owner's value stays readable.
- Drives the 16-bit value bus that feeds the display driver's input_data. It does not touch digit scanning.

---
 rtl/display_share_arbiter.sv | 157 +++++++++++++++
 tb/tb_display_share_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/display_share_arbiter.sv
// Round-robin owner selection for the shared 4-digit seven-segment value bus.
// An owner keeps the display for at least HOLD_CYCLES unless it drops its request.
module display_share_arbiter #(
  parameter logic [31:0] HOLD_CYCLES = 32'd50000000
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [2:0]  req_i,
  input  logic [15:0] data0_i,
  input  logic [15:0] data1_i,
  input  logic [15:0] data2_i,
  output logic [2:0]  grant_o,
  output logic [1:0]  disp_owner_o,
  output logic [15:0] disp_data_o,
  output logic        switch_o,
  output logic        idle_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [31:0] RELOAD = HOLD_CYCLES - 32'd1;

  state_t      state, state_n;
  logic [1:0]  owner, owner_n;
  logic [2:0]  grant, grant_n;
  logic [1:0]  ptr, ptr_n;
  logic [31:0] cnt, cnt_n;
  logic [15:0] data, data_n;
  logic        switch_q, switch_n;
  logic        idle, idle_n;

  logic [1:0]  pick;
  logic        any_req;
  logic        owner_req;
  logic        others_req;
  logic        do_grant;
  logic [15:0] owner_data;

  // Search starts one past the last owner, so the last owner is tried last.
  function automatic logic [1:0] rr_pick(input logic [1:0] p, input logic [2:0] r);
    logic [1:0] res;
    res = 2'd0;
    case (p)
      2'd0:    res = r[1] ? 2'd1 : (r[2] ? 2'd2 : 2'd0);
      2'd1:    res = r[2] ? 2'd2 : (r[0] ? 2'd0 : 2'd1);
      default: res = r[0] ? 2'd0 : (r[1] ? 2'd1 : 2'd2);
    endcase
    return res;
  endfunction

  function automatic logic [15:0] sel_data(input logic [1:0] idx,
                                           input logic [15:0] d0,
                                           input logic [15:0] d1,
                                           input logic [15:0] d2);
    logic [15:0] res;
    case (idx)
      2'd0:    res = d0;
      2'd1:    res = d1;
      2'd2:    res = d2;
      default: res = 16'h0000;
    endcase
    return res;
  endfunction

  assign pick       = rr_pick(ptr, req_i);
  assign any_req    = |req_i;
  assign owner_req  = |(req_i & grant);
  assign others_req = |(req_i & ~grant);
  assign owner_data = sel_data(owner, data0_i, data1_i, data2_i);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state    <= ST_IDLE;
      owner    <= 2'd3;
      grant    <= 3'b000;
      ptr      <= 2'd2;
      cnt      <= 32'd0;
      data     <= 16'h0000;
      switch_q <= 1'b0;
      idle     <= 1'b1;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      grant    <= grant_n;
      ptr      <= ptr_n;
      cnt      <= cnt_n;
      data     <= data_n;
      switch_q <= switch_n;
      idle     <= idle_n;
    end
  end

  always_comb begin
    state_n  = state;
    owner_n  = owner;
    grant_n  = grant;
    ptr_n    = ptr;
    cnt_n    = cnt;
    data_n   = data;
    switch_n = 1'b0;
    idle_n   = idle;
    do_grant = 1'b0;

    case (state)
      ST_IDLE: begin
        if (any_req) do_grant = 1'b1;
      end
      ST_HOLD: begin
        if (!owner_req) begin
          if (any_req) begin
            do_grant = 1'b1;
          end else begin
            // Last value stays on the bus while idle.
            state_n = ST_IDLE;
            owner_n = 2'd3;
            grant_n = 3'b000;
            idle_n  = 1'b1;
          end
        end else if (cnt == 32'd0) begin
          if (others_req) begin
            do_grant = 1'b1;
          end else begin
            cnt_n  = RELOAD;
            data_n = owner_data;
          end
        end else begin
          cnt_n  = cnt - 32'd1;
          data_n = owner_data;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    if (do_grant) begin
      state_n  = ST_HOLD;
      owner_n  = pick;
      grant_n  = 3'b001 << pick;
      ptr_n    = pick;
      cnt_n    = RELOAD;
      data_n   = sel_data(pick, data0_i, data1_i, data2_i);
      switch_n = 1'b1;
      idle_n   = 1'b0;
    end
  end

  assign grant_o      = grant;
  assign disp_owner_o = owner;
  assign disp_data_o  = data;
  assign switch_o     = switch_q;
  assign idle_o       = idle;

endmodule

// File: tb/tb_display_share_arbiter.sv
// Directed bench for display_share_arbiter with HOLD_CYCLES=4.
module tb_display_share_arbiter;

  logic        clk_in = 1'b0;
  logic        rst;
  logic [2:0]  req_i;
  logic [15:0] data0_i, data1_i, data2_i;
  logic [2:0]  grant_o;
  logic [1:0]  disp_owner_o;
  logic [15:0] disp_data_o;
  logic        switch_o;
  logic        idle_o;

  int n_checks = 0;
  int n_fails  = 0;

  display_share_arbiter #(.HOLD_CYCLES(32'd4)) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .req_i        (req_i),
    .data0_i      (data0_i),
    .data1_i      (data1_i),
    .data2_i      (data2_i),
    .grant_o      (grant_o),
    .disp_owner_o (disp_owner_o),
    .disp_data_o  (disp_data_o),
    .switch_o     (switch_o),
    .idle_o       (idle_o)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [2:0] g, input logic [1:0] o,
                           input logic [15:0] d, input logic s, input logic i);
    check({tag, ".grant"},  32'(grant_o), 32'(g));
    check({tag, ".owner"},  32'(disp_owner_o), 32'(o));
    check({tag, ".data"},   32'(disp_data_o), 32'(d));
    check({tag, ".switch"}, 32'(switch_o), 32'(s));
    check({tag, ".idle"},   32'(idle_o), 32'(i));
  endtask

  initial begin
    int sw_count;
    logic [2:0] exp_g;
    logic [15:0] exp_d;
    int idx;

    rst = 1'b1; req_i = 3'b000;
    data0_i = 16'hAAAA; data1_i = 16'h1234; data2_i = 16'hCCCC;
    tick(); tick();
    check_all("reset", 3'b000, 2'd3, 16'h0000, 1'b0, 1'b1);

    // Single requester, data follow-through, release to idle
    rst = 1'b0; req_i = 3'b010;
    tick();
    check_all("single_grant", 3'b010, 2'd1, 16'h1234, 1'b1, 1'b0);
    tick();
    check("single_sw_drop", 32'(switch_o), 32'd0);
    tick();
    data1_i = 16'h5678;
    tick();
    check("single_data_follow", 32'(disp_data_o), 32'h5678);
    req_i = 3'b000;
    tick();
    check_all("single_release", 3'b000, 2'd3, 16'h5678, 1'b0, 1'b1);

    // Pointer at 1: search starts at 2, wraps to 0
    req_i = 3'b011;
    tick();
    check_all("fair_pick0", 3'b001, 2'd0, 16'hAAAA, 1'b1, 1'b0);
    req_i = 3'b000;
    tick();
    check("fair_idle", 32'(idle_o), 32'd1);

    // Reset mid-operation
    data1_i = 16'hBBBB;
    req_i = 3'b111;
    tick();
    check("pre_reset_grant", 32'(grant_o), 32'b010);
    tick();
    rst = 1'b1;
    tick();
    check_all("mid_reset", 3'b000, 2'd3, 16'h0000, 1'b0, 1'b1);
    rst = 1'b0;

    // Full rotation, 14 cycles
    for (int c = 1; c <= 14; c++) begin
      tick();
      idx = ((c - 1) / 4) % 3;
      exp_g = 3'b001 << idx;
      exp_d = (idx == 0) ? 16'hAAAA : (idx == 1) ? 16'hBBBB : 16'hCCCC;
      check($sformatf("rot%0d", c), {20'd0, idle_o, switch_o, exp_d === disp_data_o, 6'd0, grant_o},
            {20'd0, 1'b0, ((c - 1) % 4) == 0, 1'b1, 6'd0, exp_g});
    end

    // Early release after 2 cycles of owner-0 hold
    req_i = 3'b100;
    tick();
    check_all("early_switch", 3'b100, 2'd2, 16'hCCCC, 1'b1, 1'b0);
    req_i = 3'b000;
    tick();
    check_all("early_idle", 3'b000, 2'd3, 16'hCCCC, 1'b0, 1'b1);

    // Sole requester renews without switch pulses
    req_i = 3'b001;
    sw_count = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (switch_o) sw_count++;
      check($sformatf("renew%0d.grant", c), 32'(grant_o), 32'b001);
      check($sformatf("renew%0d.switch", c), 32'(switch_o), 32'(c == 1));
    end
    check("renew_switch_count", 32'(sw_count), 32'd1);

    // Counter at 0 now; a new request is served on expiry
    req_i = 3'b011;
    tick();
    check_all("expiry_switch", 3'b010, 2'd1, 16'hBBBB, 1'b1, 1'b0);
    tick();
    check("no_preempt", 32'(grant_o), 32'b010);
    tick(); tick();
    // Release coinciding with expiry
    req_i = 3'b001;
    tick();
    check_all("release_at_expiry", 3'b001, 2'd0, 16'hAAAA, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
